// File: rtl/sbus_arb_pkg.sv
// Shared definitions for the two-master SBUS arbiter: FSM state encoding and
// master index constants.
package sbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/sbus_arbiter.sv
// Two-master round-robin arbiter onto a single 8-bit slave bus; each granted
// transaction runs IDLE -> STROBE -> CAPTURE -> ACK, with optional lock for bursts.
module sbus_arbiter
    import sbus_arb_pkg::*;
#(
    parameter int ABUSWIDTH = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,

    input  logic                 M0_REQ,
    input  logic                 M0_WR,
    input  logic [ABUSWIDTH-1:0] M0_ADD,
    input  logic [7:0]           M0_DATA_IN,
    input  logic                 M0_LOCK,
    output logic                 M0_ACK,
    output logic [7:0]           M0_DATA_OUT,

    input  logic                 M1_REQ,
    input  logic                 M1_WR,
    input  logic [ABUSWIDTH-1:0] M1_ADD,
    input  logic [7:0]           M1_DATA_IN,
    input  logic                 M1_LOCK,
    output logic                 M1_ACK,
    output logic [7:0]           M1_DATA_OUT,

    output logic [ABUSWIDTH-1:0] S_ADD,
    output logic [7:0]           S_DATA_OUT,
    input  logic [7:0]           S_DATA_IN,
    output logic                 S_RD,
    output logic                 S_WR,

    output logic                 GRANT,
    output logic                 BUSY
);

    arb_state_e           state;
    logic                 grant_q;
    logic                 lock_q;
    logic                 wr_q;
    logic [ABUSWIDTH-1:0] add_q;
    logic [7:0]           data_q;
    logic [7:0]           m0_dout_q;
    logic [7:0]           m1_dout_q;

    logic                 any_req;
    logic                 granted_req;
    logic                 granted_lock;
    logic                 winner;
    logic                 sel_wr;
    logic [ABUSWIDTH-1:0] sel_add;
    logic [7:0]           sel_data;

    // Round-robin pick: a lock held through the last ACK beats the other
    // requester, otherwise a tie goes to the master that did not have the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        any_req      = M0_REQ | M1_REQ;
        granted_req  = (grant_q == M1) ? M1_REQ  : M0_REQ;
        granted_lock = (grant_q == M1) ? M1_LOCK : M0_LOCK;
        winner       = grant_q;

        if (lock_q && granted_req) begin
            winner = grant_q;
        end else if (M0_REQ && M1_REQ) begin
            winner = ~grant_q;
        end else if (M0_REQ) begin
            winner = M0;
        end else begin
            winner = M1;
        end

        sel_wr   = (winner == M1) ? M1_WR      : M0_WR;
        sel_add  = (winner == M1) ? M1_ADD     : M0_ADD;
        sel_data = (winner == M1) ? M1_DATA_IN : M0_DATA_IN;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state     <= IDLE;
            grant_q   <= M1;
            lock_q    <= 1'b0;
            wr_q      <= 1'b0;
            add_q     <= '0;
            data_q    <= '0;
            m0_dout_q <= '0;
            m1_dout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Lock only survives into the first IDLE cycle after ACK.
                    lock_q <= 1'b0;
                    if (any_req) begin
                        grant_q <= winner;
                        wr_q    <= sel_wr;
                        add_q   <= sel_add;
                        data_q  <= sel_data;
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!wr_q) begin
                        if (grant_q == M1) begin
                            m1_dout_q <= S_DATA_IN;
                        end else begin
                            m0_dout_q <= S_DATA_IN;
                        end
                    end
                    state <= ACK;
                end
                ACK: begin
                    lock_q <= granted_lock;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes and ACKs decode straight from state so reset clears them at once.
    assign S_RD        = (state == STROBE) && !wr_q;
    assign S_WR        = (state == STROBE) &&  wr_q;
    assign S_ADD       = add_q;
    assign S_DATA_OUT  = data_q;
    assign M0_ACK      = (state == ACK) && (grant_q == M0);
    assign M1_ACK      = (state == ACK) && (grant_q == M1);
    assign M0_DATA_OUT = m0_dout_q;
    assign M1_DATA_OUT = m1_dout_q;
    assign GRANT       = grant_q;
    assign BUSY        = (state != IDLE);

endmodule
